// File: rtl/div_result_buffer.sv
// Reorder-free result buffer behind a pipelined divider: credit-based issue control
// plus a first-word fall-through circular store with a sticky overflow flag.
module div_result_buffer #(
    parameter int N     = 20,
    parameter int M     = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     issue_i,
    output logic                     credit_o,
    input  logic                     valid_i,
    input  logic [N-1:0]             quotient_i,
    input  logic [M-1:0]             remainder_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [N-1:0]             quotient_o,
    output logic [M-1:0]             remainder_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [N+M-1:0]   mem_q [DEPTH];

    logic             pop;
    logic             push;
    logic             issue_ok;

    assign credit_o   = (outstanding_q < FULL);
    assign valid_o    = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign {quotient_o, remainder_o} = mem_q[rd_ptr_q];

    always_comb begin
        pop      = valid_o & ready_i;
        issue_ok = issue_i & credit_o;
        // A pop in the same cycle frees the slot the incoming result needs.
        push     = valid_i & ((count_q != FULL) | pop);

        outstanding_d = outstanding_q;
        if (issue_ok && !pop) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (pop && !issue_ok) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (valid_i & ~push) | (issue_i & ~credit_o);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; valid_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {quotient_i, remainder_i};
        end
    end

endmodule

// File: tb/tb_div_result_buffer.sv
// Scoreboard bench for div_result_buffer with a behavioural pipelined signed divider.
module tb_div_result_buffer;

    localparam int N     = 20;
    localparam int M     = 20;
    localparam int DEPTH = 8;
    localparam int LAT   = N + 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          issue_i;
    logic          credit_o;
    logic          valid_i;
    logic [N-1:0]  quotient_i;
    logic [M-1:0]  remainder_i;
    logic          valid_o;
    logic          ready_i;
    logic [N-1:0]  quotient_o;
    logic [M-1:0]  remainder_o;
    logic [3:0]    count_o;
    logic          overflow_o;

    typedef struct {
        logic [N-1:0]        q;
        logic [M-1:0]        r;
        logic signed [N-1:0] a;
        logic signed [M-1:0] b;
        logic                has_div;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    div_result_buffer #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .issue_i     (issue_i),
        .credit_o    (credit_o),
        .valid_i     (valid_i),
        .quotient_i  (quotient_i),
        .remainder_i (remainder_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        issue_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        quotient_i  = '0;
        remainder_i = '0;
        sb.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle();
    endtask

    task automatic fill_buffer(input int qbase);
        sb_t e;
        for (int i = 0; i < DEPTH; i++) begin
            issue_i = 1'b1;
            cycle();
        end
        issue_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_i     = 1'b1;
            quotient_i  = N'(qbase + i);
            remainder_i = M'(1000 + qbase + i);
            e.q = quotient_i; e.r = remainder_i; e.a = '0; e.b = '0; e.has_div = 1'b0;
            sb.push_back(e);
            cycle();
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (credit_o !== 1'b1) $display("FAIL reset_credit: got %b want 1", credit_o); else n_pass++;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++;
        if (count_o !== 4'd0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_o); else n_pass++;
    endtask

    task automatic test_fill();
        sb_t e;
        ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (credit_o !== 1'b1) $display("FAIL fill_credit_before_%0d: got %b want 1", i, credit_o); else n_pass++;
            issue_i = 1'b1;
            cycle();
        end
        issue_i = 1'b0;
        n_checks++;
        if (credit_o !== 1'b0) $display("FAIL fill_credit_after_8: got %b want 0", credit_o); else n_pass++;
        for (int i = 1; i <= DEPTH; i++) begin
            valid_i     = 1'b1;
            quotient_i  = N'(i);
            remainder_i = M'(i * 3);
            e.q = quotient_i; e.r = remainder_i; e.a = '0; e.b = '0; e.has_div = 1'b0;
            sb.push_back(e);
            if (i == 1) begin
                n_checks++;
                if (valid_o !== 1'b0) $display("FAIL fill_no_bypass: got %b want 0", valid_o); else n_pass++;
            end
            cycle();
            if (i == 1) begin
                n_checks++;
                if (valid_o !== 1'b1) $display("FAIL fill_valid_next_cycle: got %b want 1", valid_o); else n_pass++;
            end
        end
        valid_i = 1'b0;
        n_checks++;
        if (count_o !== 4'd8) $display("FAIL fill_count: got %0d want 8", count_o); else n_pass++;
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL fill_overflow: got %b want 0", overflow_o); else n_pass++;
    endtask

    task automatic test_drain();
        sb_t e;
        ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (valid_o !== 1'b1) begin
                $display("FAIL drain_valid_%0d: got %b want 1", i, valid_o);
            end else begin
                e = sb.pop_front();
                if (quotient_o !== e.q || remainder_o !== e.r)
                    $display("FAIL drain_data_%0d: got q=%0d r=%0d want q=%0d r=%0d", i, quotient_o, remainder_o, e.q, e.r);
                else n_pass++;
            end
            cycle();
            if (i == 0) begin
                n_checks++;
                if (credit_o !== 1'b1) $display("FAIL drain_credit_after_pop: got %b want 1", credit_o); else n_pass++;
            end
        end
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL drain_valid_end: got %b want 0", valid_o); else n_pass++;
        n_checks++;
        if (count_o !== 4'd0) $display("FAIL drain_count_end: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        sb_t e;
        sb_t n;
        apply_reset();
        fill_buffer(11);
        valid_i     = 1'b1;
        ready_i     = 1'b1;
        quotient_i  = N'(99);
        remainder_i = M'(-5);
        e = sb.pop_front();
        n_checks++;
        if (quotient_o !== e.q || remainder_o !== e.r)
            $display("FAIL fpp_head: got q=%0d want q=%0d", quotient_o, e.q);
        else n_pass++;
        n.q = quotient_i; n.r = remainder_i; n.a = '0; n.b = '0; n.has_div = 1'b0;
        sb.push_back(n);
        cycle();
        valid_i = 1'b0;
        ready_i = 1'b0;
        n_checks++;
        if (count_o !== 4'd8) $display("FAIL fpp_count: got %0d want 8", count_o); else n_pass++;
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL fpp_overflow: got %b want 0", overflow_o); else n_pass++;
        ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (valid_o !== 1'b1 || quotient_o !== e.q || remainder_o !== e.r)
                $display("FAIL fpp_order_%0d: got v=%b q=%0d r=%0h want v=1 q=%0d r=%0h",
                         i, valid_o, quotient_o, remainder_o, e.q, e.r);
            else n_pass++;
            cycle();
        end
        ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        sb_t e;
        apply_reset();
        fill_buffer(21);
        valid_i    = 1'b1;
        ready_i    = 1'b0;
        quotient_i = N'(777);
        remainder_i = M'(777);
        cycle();
        valid_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_push_flag: got %b want 1", overflow_o); else n_pass++;
        n_checks++;
        if (count_o !== 4'd8) $display("FAIL ovf_push_count: got %0d want 8", count_o); else n_pass++;
        ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (valid_o !== 1'b1 || quotient_o !== e.q || remainder_o !== e.r)
                $display("FAIL ovf_drain_%0d: got v=%b q=%0d want v=1 q=%0d", i, valid_o, quotient_o, e.q);
            else n_pass++;
            cycle();
        end
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL ovf_dropped_absent: got valid=%b q=%0d want valid 0", valid_o, quotient_o); else n_pass++;
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o); else n_pass++;

        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            issue_i = 1'b1;
            cycle();
        end
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_issue_pre: got %b want 0", overflow_o); else n_pass++;
        issue_i = 1'b1;
        cycle();
        issue_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_issue_flag: got %b want 1", overflow_o); else n_pass++;
        n_checks++;
        if (credit_o !== 1'b0) $display("FAIL ovf_issue_credit: got %b want 0", credit_o); else n_pass++;
        apply_reset();
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_reset_clear: got %b want 0", overflow_o); else n_pass++;
    endtask

    task automatic test_random();
        logic                pv [LAT];
        logic [N-1:0]        pq [LAT];
        logic [M-1:0]        pr [LAT];
        logic signed [N-1:0] a, q;
        logic signed [M-1:0] b, r;
        longint              recon;
        sb_t                 e;
        int                  issued = 0;
        int                  cycles = 0;
        int                  inflight;
        apply_reset();
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0; pq[i] = '0; pr[i] = '0;
        end
        forever begin
            inflight = 0;
            for (int i = 0; i < LAT; i++) if (pv[i]) inflight++;
            if (issued >= 1000 && sb.size() == 0 && inflight == 0) break;
            if (cycles > 20000) begin
                n_checks++;
                $display("FAIL rand_timeout: issued=%0d pending=%0d want all drained", issued, sb.size());
                break;
            end
            valid_i     = pv[LAT-1];
            quotient_i  = pq[LAT-1];
            remainder_i = pr[LAT-1];
            for (int i = LAT-1; i > 0; i--) begin
                pv[i] = pv[i-1]; pq[i] = pq[i-1]; pr[i] = pr[i-1];
            end
            if (credit_o && issued < 1000 && $urandom_range(0, 9) < 7) begin
                a = N'($urandom);
                if ($urandom_range(0, 1) == 1) b = M'($urandom_range(1, 500));
                else b = M'($urandom);
                if (b == '0) b = M'(1);
                if ($urandom_range(0, 1) == 1) b = -b;
                if (a == {1'b1, {(N-1){1'b0}}} && b == -1) a = a + 1'b1;
                q = a / b;
                r = a % b;
                issue_i = 1'b1;
                pv[0] = 1'b1; pq[0] = q; pr[0] = r;
                e.q = q; e.r = r; e.a = a; e.b = b; e.has_div = 1'b1;
                sb.push_back(e);
                issued++;
            end else begin
                issue_i = 1'b0;
                pv[0] = 1'b0;
            end
            ready_i = ($urandom_range(0, 9) < 6);
            if (valid_o && ready_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_unexpected_output: got q=%0d want none", quotient_o);
                end else begin
                    e = sb.pop_front();
                    recon = longint'($signed(quotient_o)) * longint'(e.b) + longint'($signed(remainder_o));
                    if (quotient_o !== e.q || remainder_o !== e.r || recon != longint'(e.a))
                        $display("FAIL rand_data: got q=%0d r=%0d want q=%0d r=%0d (a=%0d b=%0d)",
                                 $signed(quotient_o), $signed(remainder_o), $signed(e.q), $signed(e.r), e.a, e.b);
                    else n_pass++;
                end
            end
            cycle();
            cycles++;
        end
        issue_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL rand_overflow: got %b want 0", overflow_o); else n_pass++;
        n_checks++;
        if (count_o !== 4'd0) $display("FAIL rand_count_end: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        sb_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            issue_i = 1'b1;
            cycle();
        end
        issue_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            quotient_i = N'(50 + i);
            remainder_i = M'(i);
            cycle();
        end
        valid_i = 1'b0;
        n_checks++;
        if (count_o !== 4'd5) $display("FAIL rmid_count_before: got %0d want 5", count_o); else n_pass++;
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 4'd0 || credit_o !== 1'b1)
            $display("FAIL rmid_async: got v=%b cnt=%0d cr=%b want v=0 cnt=0 cr=1", valid_o, count_o, credit_o);
        else n_pass++;
        sb.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle();
        issue_i = 1'b1;
        cycle();
        issue_i = 1'b0;
        valid_i = 1'b1;
        quotient_i = N'(42);
        remainder_i = M'(-7);
        e.q = quotient_i; e.r = remainder_i; e.a = '0; e.b = '0; e.has_div = 1'b0;
        sb.push_back(e);
        cycle();
        valid_i = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (valid_o !== 1'b1 || quotient_o !== e.q || remainder_o !== e.r || count_o !== 4'd1)
            $display("FAIL rmid_resume: got v=%b q=%0d r=%0h cnt=%0d want v=1 q=%0d r=%0h cnt=1",
                     valid_o, quotient_o, remainder_o, count_o, e.q, e.r);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 Parameter N, default 20, dividend/quotient width in bits.
REQ-002 Parameter M, default 20, divisor/remainder width in bits.
REQ-003 Parameter DEPTH, default 8, result storage entries; power of two, at least 2.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 issue_i  in  1  upstream presents one operand pair to the divider this cycle.
REQ-007 credit_o  out  1  high when the upstream may issue this cycle.
REQ-008 valid_i  in  1  divider result valid; no backpressure is possible on this side.
REQ-009 quotient_i  in  N  signed divider quotient.
REQ-010 remainder_i  in  M  signed divider remainder.
REQ-011 valid_o  out  1  head result available to the consumer.
REQ-012 ready_i  in  1  consumer accepts the head result.
REQ-013 quotient_o  out  N  head quotient.
REQ-014 remainder_o  out  M  head remainder.
REQ-015 count_o  out  $clog2(DEPTH)+1  entries currently stored.
REQ-016 overflow_o  out  1  sticky error flag.

Function
REQ-017 outstanding counter: width $clog2(DEPTH)+1; counts issued results not yet popped, including results still in the divider pipeline.
REQ-018 credit_o shall equal (outstanding < DEPTH), combinational from the register.
REQ-019 Accepted issue: issue_i & credit_o.
REQ-020 Pop: valid_o & ready_i.
REQ-021 outstanding: +1 on accepted issue only; -1 on pop only; unchanged when both occur in the same cycle.
REQ-022 issue_i while credit_o=0: counter unchanged; overflow_o set to 1.
REQ-023 Storage: circular buffer, DEPTH entries, write/read pointers wrap modulo DEPTH.
REQ-024 Push: valid_i writes {quotient_i, remainder_i} at the write pointer, provided count_o<DEPTH or a pop occurs in the same cycle.
REQ-025 valid_i while full with no pop: data dropped, pointers unchanged, overflow_o set to 1.
REQ-026 Simultaneous push and pop: count_o unchanged, both pointers advance, data order preserved.
REQ-027 Output: first-word fall-through; valid_o = (count_o != 0); quotient_o/remainder_o driven from the entry at the read pointer.
REQ-028 No bypass: a push into an empty buffer raises valid_o exactly one cycle later.
REQ-029 pop with count_o=0 is impossible, because valid_o=0 then.
REQ-030 Arithmetic: data stored bit-exact; no sign extension, truncation or modification.
REQ-031 overflow_o stays 1 until reset; it has no other clear.
REQ-032 Block latency: push-to-valid_o 1 cycle; pop-to-next-head 0 cycles (head updates combinationally after the pointer register).
REQ-033 Invariant in correct use: count_o <= outstanding <= DEPTH.

Reset
REQ-034 rst_n_i low: credit_o=1, valid_o=0, count_o=0, overflow_o=0, outstanding=0, pointers=0, immediately and asynchronously.
REQ-035 Storage array is not reset; quotient_o/remainder_o are don't-care while valid_o=0.
REQ-036 Reset mid-operation discards all stored and in-flight results. Results the divider emits after reset release are pushed normally; the upstream owns any resulting mismatch.

Verification
REQ-037 Set DEPTH=8, ready_i=0, and drive 8 accepted issues. Return 8 results with quotients 1..8. Required: credit_o=0 after the 8th issue, count_o=8, overflow_o=0.
REQ-038 Continue the REQ-037 state with ready_i=1 for 8 cycles. Required: quotient_o sequence 1..8 in order, credit_o=1 after the first pop, valid_o=0 after the 8th pop.
REQ-039 With the buffer full, drive valid_i and ready_i high in the same cycle. Required: count_o stays 8, the new entry appears last, overflow_o=0.
REQ-040 With the buffer full, drive valid_i with ready_i=0. Required: overflow_o=1 permanently, count_o=8, and the dropped data never appears. A separate case drives issue_i with credit_o=0 and also requires overflow_o=1.
REQ-041 Run 1000 random signed results with random ready_i, with issue gated by credit_o, against a pipelined signed divider of latency N+2. Required: outputs match the scoreboard in order, quotient*divisor+remainder==dividend, overflow_o=0.
REQ-042 Assert rst_n_i low with count_o=5 mid-stream. Required: valid_o=0, count_o=0 and credit_o=1 immediately; after release, normal operation resumes with pointers at 0.
